// File: rtl/vga_timing_gen_if.sv
// VGA timing bundle: syncs, blank, pixel clock, pixel coordinates and per-frame tick.
// The timing generator drives the master side; pixel/colour consumers use the slave side.
interface vga_timing_gen_if;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       VGA_SYNC_N;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       frame_tick;

  modport master (
    output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
    output DrawX, DrawY, frame_tick
  );

  modport slave (
    input VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
    input DrawX, DrawY, frame_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60Hz VGA timing from a 50 MHz clock (one pixel every second Clk) plus a frame tick.
// Define VGA_SYNC_DELAY_EN to delay HS/VS/BLANK_N by one pixel to match a registered RGB stage.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic              Clk,
  input  logic              Reset,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic       pix_en;
  logic       vga_clk_q;
  logic [9:0] x_q, y_q;
  logic [9:0] x_nxt, y_nxt;
  logic       hs_q, vs_q, blank_n_q, tick_q;
  logic       hs_nxt, vs_nxt, blank_n_nxt;

  // Next-pixel position and its decode; the syncs are registered from these so they
  // line up with DrawX/DrawY on the same edge.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    x_nxt = x_q + 10'd1;
    y_nxt = y_q;
    if (x_q == H_LAST) begin
      x_nxt = '0;
      y_nxt = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end
    hs_nxt      = !((x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST));
    vs_nxt      = !((y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST));
    blank_n_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pix_en    <= 1'b0;
      vga_clk_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      pix_en    <= ~pix_en;
      vga_clk_q <= pix_en;
      tick_q    <= pix_en && (x_nxt == '0) && (y_nxt == V_VIS);
      if (pix_en) begin
        x_q       <= x_nxt;
        y_q       <= y_nxt;
        hs_q      <= hs_nxt;
        vs_q      <= vs_nxt;
        blank_n_q <= blank_n_nxt;
      end
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hs_d, vs_d, blank_n_d;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hs_d      <= 1'b1;
      vs_d      <= 1'b1;
      blank_n_d <= 1'b0;
    end else if (pix_en) begin
      hs_d      <= hs_q;
      vs_d      <= vs_q;
      blank_n_d <= blank_n_q;
    end
  end

  assign vga.VGA_HS      = hs_d;
  assign vga.VGA_VS      = vs_d;
  assign vga.VGA_BLANK_N = blank_n_d;
`else
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.VGA_BLANK_N = blank_n_q;
`endif

  assign vga.VGA_CLK    = vga_clk_q;
  assign vga.VGA_SYNC_N = 1'b0;
  assign vga.DrawX      = x_q;
  assign vga.DrawY      = y_q;
  assign vga.frame_tick = tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line timing, shrunken instance for frame timing.
// Expected sync/blank lag follows VGA_SYNC_DELAY_EN when it is defined for the build.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 0;
`endif

  // Shrunken geometry: H_TOTAL=32, V_TOTAL=20
  localparam int SH_VIS = 16, SH_FP = 4, SH_SYNC = 6, SH_BP = 6;
  localparam int SV_VIS = 12, SV_FP = 2, SV_SYNC = 2, SV_BP = 4;

  logic Clk = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   fails = 0;
  int   t0, t1, n;

  vga_timing_gen_if d_if ();
  vga_timing_gen_if s_if ();

  vga_timing_gen dut_d (
    .Clk   (Clk),
    .Reset (Reset),
    .vga   (d_if.master)
  );

  vga_timing_gen #(
    .H_VISIBLE (SH_VIS), .H_FP (SH_FP), .H_SYNC (SH_SYNC), .H_BP (SH_BP),
    .V_VISIBLE (SV_VIS), .V_FP (SV_FP), .V_SYNC (SV_SYNC), .V_BP (SV_BP)
  ) dut_s (
    .Clk   (Clk),
    .Reset (Reset),
    .vga   (s_if.master)
  );

  always #10 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b0;

    // Reset held for 3 Clk
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("rst_tick_d", d_if.frame_tick, 0);
      check("rst_tick_s", s_if.frame_tick, 0);
    end
    check("rst_hs", d_if.VGA_HS, 1);
    check("rst_vs", d_if.VGA_VS, 1);
    check("rst_blank", d_if.VGA_BLANK_N, 0);
    check("rst_x", d_if.DrawX, 0);
    check("rst_y", d_if.DrawY, 0);
    check("rst_vgaclk", d_if.VGA_CLK, 0);
    check("sync_n", d_if.VGA_SYNC_N, 0);

    // Release; first edge only raises pix_en, second advances the pixel
    Reset = 1'b1;
    t0 = cyc;
    @(negedge Clk);
    check("e1_vgaclk", d_if.VGA_CLK, 0);
    check("e1_x", d_if.DrawX, 0);
    @(negedge Clk);
    check("e2_vgaclk", d_if.VGA_CLK, 1);
    check("e2_x", d_if.DrawX, 1);
    @(negedge Clk);
    check("e3_vgaclk", d_if.VGA_CLK, 0);
    check("e3_x", d_if.DrawX, 1);

    // First frame tick of the small instance: 2*32*12 Clk after release
    n = 0;
    while (s_if.frame_tick !== 1'b1 && n < 5000) begin @(negedge Clk); n++; end
    check("tick1_seen", s_if.frame_tick, 1);
    check("tick1_delay", cyc - t0, 2 * 32 * SV_VIS);
    check("tick1_x", s_if.DrawX, 0);
    check("tick1_y", s_if.DrawY, SV_VIS);
    @(negedge Clk);
    check("tick1_width", s_if.frame_tick, 0);

    // Full-size horizontal timing
    n = 0;
    while (d_if.DrawX !== 10'd639 && n < 4000) begin @(negedge Clk); n++; end
    check("reach_x639", d_if.DrawX, 639);
    check("blank_x639", d_if.VGA_BLANK_N, 1);
    check("y_line0", d_if.DrawY, 0);
    t1 = cyc;
    n = 0;
    while (d_if.DrawX !== 10'd640 && n < 100) begin @(negedge Clk); n++; end
    check("x639_to_640", cyc - t1, 2);
    check("blank_at_640", d_if.VGA_BLANK_N, (LAG == 0) ? 0 : 1);
    t1 = cyc;
    repeat (LAG) @(negedge Clk);
    check("blank_fall", d_if.VGA_BLANK_N, 0);

    n = 0;
    while (d_if.DrawX !== 10'd656 && n < 200) begin @(negedge Clk); n++; end
    check("x640_to_656", cyc - t1, 32);
    check("hs_at_656", d_if.VGA_HS, (LAG == 0) ? 0 : 1);
    repeat (LAG) @(negedge Clk);
    check("hs_fall", d_if.VGA_HS, 0);
    n = 0;
    while (d_if.VGA_HS === 1'b0 && n < 1000) begin @(negedge Clk); n++; end
    check("hs_low_clk", n, 192);
    check("hs_rise_x", d_if.DrawX, 752 + LAG / 2);

    n = 0;
    while (d_if.DrawX !== 10'd799 && n < 400) begin @(negedge Clk); n++; end
    check("reach_x799", d_if.DrawX, 799);
    check("hs_x799", d_if.VGA_HS, 1);
    t1 = cyc;
    n = 0;
    while (d_if.DrawX !== 10'd0 && n < 100) begin @(negedge Clk); n++; end
    check("x799_to_0", cyc - t1, 2);
    check("y_inc_wrap", d_if.DrawY, 1);
    t1 = cyc;
    n = 0;
    while (d_if.DrawY !== 10'd2 && n < 4000) begin @(negedge Clk); n++; end
    check("line_period", cyc - t1, 1600);
    check("line2_x", d_if.DrawX, 0);

    // Small instance: vertical sync, wrap, frame period
    n = 0;
    while (s_if.DrawY !== 10'(SV_VIS + SV_FP) && n < 3000) begin @(negedge Clk); n++; end
    check("reach_vs_line", s_if.DrawY, SV_VIS + SV_FP);
    check("vs_at_start", s_if.VGA_VS, (LAG == 0) ? 0 : 1);
    repeat (LAG) @(negedge Clk);
    check("vs_fall", s_if.VGA_VS, 0);
    n = 0;
    while (s_if.VGA_VS === 1'b0 && n < 1000) begin @(negedge Clk); n++; end
    check("vs_low_clk", n, 2 * 2 * 32);
    check("vs_rise_y", s_if.DrawY, SV_VIS + SV_FP + SV_SYNC);

    n = 0;
    while (s_if.DrawY !== 10'd19 && n < 3000) begin @(negedge Clk); n++; end
    check("reach_ylast", s_if.DrawY, 19);
    n = 0;
    while (s_if.DrawY !== 10'd0 && n < 200) begin @(negedge Clk); n++; end
    check("y_wrap", s_if.DrawY, 0);
    check("y_wrap_x", s_if.DrawX, 0);

    n = 0;
    while (s_if.frame_tick !== 1'b1 && n < 3000) begin @(negedge Clk); n++; end
    check("tick2_seen", s_if.frame_tick, 1);
    t1 = cyc;
    @(negedge Clk);
    n = 0;
    while (s_if.frame_tick !== 1'b1 && n < 3000) begin @(negedge Clk); n++; end
    check("tick_period", cyc - t1, 2 * 32 * 20);

    // Mid-frame asynchronous reset
    n = 0;
    while (s_if.DrawY !== 10'd7 && n < 3000) begin @(negedge Clk); n++; end
    check("reach_y7", s_if.DrawY, 7);
    #3 Reset = 1'b0;
    #1;
    check("arst_x_s", s_if.DrawX, 0);
    check("arst_y_s", s_if.DrawY, 0);
    check("arst_blank_s", s_if.VGA_BLANK_N, 0);
    check("arst_hs_s", s_if.VGA_HS, 1);
    check("arst_vs_s", s_if.VGA_VS, 1);
    check("arst_vgaclk_d", d_if.VGA_CLK, 0);
    check("arst_x_d", d_if.DrawX, 0);
    check("arst_tick_s", s_if.frame_tick, 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    t0 = cyc;
    n = 0;
    while (s_if.frame_tick !== 1'b1 && n < 3000) begin @(negedge Clk); n++; end
    check("rst_tick_seen", s_if.frame_tick, 1);
    check("rst_tick_delay", cyc - t0, 2 * 32 * SV_VIS);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
